// File: rtl/lsu_ram_ctrl.sv
// Load/store controller between the core memory stage and a word-organised data RAM.
// Sub-word stores use read-modify-write; loads extract and extend the addressed lane.
module lsu_ram_ctrl #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 32
) (
  input  logic          CLK,
  input  logic          RSTa,
  input  logic          REQ,
  input  logic          WE,
  input  logic [2:0]    FUNCT3,
  input  logic [31:0]   ADDR,
  input  logic [DW-1:0] WDATA,
  output logic          BUSY,
  output logic          DONE,
  output logic          ERR,
  output logic [DW-1:0] RDATA,
  output logic          RAM_WR,
  output logic          RAM_OE,
  output logic [AW-1:0] RAM_ADDRESS,
  output logic [DW-1:0] RAM_DATA_IN,
  input  logic [DW-1:0] RAM_DATA_OUT
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    STORE  = 3'd2,
    RMW_RD = 3'd3,
    RMW_WR = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    f3_q;
  logic [1:0]    addr_lo_q;
  logic [15:0]   lane_data_q;

  logic          accept;
  logic          misaligned, out_of_range, illegal_f3;
  logic          done_d, err_d, wr_d, oe_d;
  logic [DW-1:0] rdata_d, ram_din_d;
  logic [DW-1:0] load_shift, load_ext, merge_word;

  // Request validation on the live inputs at the accept edge
  always_comb begin
    misaligned   = ((FUNCT3[1:0] == 2'b01) && ADDR[0]) ||
                   ((FUNCT3[1:0] == 2'b10) && (ADDR[1:0] != 2'b00));
    out_of_range = (ADDR >> (AW + 2)) != 32'd0;
    illegal_f3   = WE ? (FUNCT3 >= 3'b011)
                      : ((FUNCT3 == 3'b011) || (FUNCT3[2:1] == 2'b11));
  end

  // Lane extraction; aligned halfwords make the byte shift equal ADDR[1]*16
  always_comb begin
    load_shift = RAM_DATA_OUT >> {addr_lo_q, 3'b000};
    case (f3_q)
      3'b000:  load_ext = {{(DW-8){load_shift[7]}}, load_shift[7:0]};
      3'b001:  load_ext = {{(DW-16){load_shift[15]}}, load_shift[15:0]};
      3'b100:  load_ext = {{(DW-8){1'b0}}, load_shift[7:0]};
      3'b101:  load_ext = {{(DW-16){1'b0}}, load_shift[15:0]};
      default: load_ext = RAM_DATA_OUT;
    endcase
  end

  // Replace the target lane of the read word with the store data
  always_comb begin
    merge_word = RAM_DATA_OUT;
    if (f3_q[0]) merge_word[{addr_lo_q[1], 4'b0000} +: 16] = lane_data_q;
    else         merge_word[{addr_lo_q, 3'b000} +: 8]     = lane_data_q[7:0];
  end

  // Next state and next registered outputs
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    wr_d      = 1'b0;
    oe_d      = 1'b0;
    rdata_d   = RDATA;
    ram_din_d = RAM_DATA_IN;
    case (state_q)
      IDLE: begin
        if (REQ) begin
          accept = 1'b1;
          if (misaligned || out_of_range || illegal_f3) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else if (!WE) begin
            state_d = LOAD;
            oe_d    = 1'b1;
          end else if (FUNCT3 == 3'b010) begin
            state_d   = STORE;
            wr_d      = 1'b1;
            ram_din_d = WDATA;
          end else begin
            state_d = RMW_RD;
            oe_d    = 1'b1;
          end
        end
      end
      LOAD: begin
        rdata_d = load_ext;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      STORE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      RMW_RD: begin
        ram_din_d = merge_word;
        wr_d      = 1'b1;
        state_d   = RMW_WR;
      end
      RMW_WR: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Registered outputs and latched request fields
  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      ERR         <= 1'b0;
      RDATA       <= '0;
      RAM_WR      <= 1'b0;
      RAM_OE      <= 1'b0;
      RAM_ADDRESS <= '0;
      RAM_DATA_IN <= '0;
      f3_q        <= '0;
      addr_lo_q   <= '0;
      lane_data_q <= '0;
    end else begin
      BUSY        <= (state_d != IDLE);
      DONE        <= done_d;
      ERR         <= err_d;
      RDATA       <= rdata_d;
      RAM_WR      <= wr_d;
      RAM_OE      <= oe_d;
      RAM_DATA_IN <= ram_din_d;
      if (accept) begin
        RAM_ADDRESS <= ADDR[AW+1:2];
        f3_q        <= FUNCT3;
        addr_lo_q   <= ADDR[1:0];
        lane_data_q <= WDATA[15:0];
      end
    end
  end

endmodule

// File: tb/tb_lsu_ram_ctrl.sv
// Directed self-checking bench for lsu_ram_ctrl with a behavioural word RAM.
module tb_lsu_ram_ctrl;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;

  logic          CLK = 1'b0;
  logic          RSTa = 1'b0;
  logic          REQ = 1'b0;
  logic          WE = 1'b0;
  logic [2:0]    FUNCT3 = '0;
  logic [31:0]   ADDR = '0;
  logic [DW-1:0] WDATA = '0;
  logic          BUSY, DONE, ERR, RAM_WR, RAM_OE;
  logic [DW-1:0] RDATA, RAM_DATA_IN;
  logic [AW-1:0] RAM_ADDRESS;
  wire  [DW-1:0] RAM_DATA_OUT;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  int tests = 0;
  int fails = 0;

  lsu_ram_ctrl #(.AW(AW), .DW(DW)) dut (
    .CLK(CLK), .RSTa(RSTa), .REQ(REQ), .WE(WE), .FUNCT3(FUNCT3), .ADDR(ADDR),
    .WDATA(WDATA), .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .RDATA(RDATA),
    .RAM_WR(RAM_WR), .RAM_OE(RAM_OE), .RAM_ADDRESS(RAM_ADDRESS),
    .RAM_DATA_IN(RAM_DATA_IN), .RAM_DATA_OUT(RAM_DATA_OUT)
  );

  always #5 CLK = ~CLK;

  assign RAM_DATA_OUT = (RAM_OE && !RAM_WR) ? mem[RAM_ADDRESS] : 'z;

  always @(posedge CLK) if (RAM_WR) mem[RAM_ADDRESS] <= RAM_DATA_IN;

  // WR and OE must never be asserted together
  always @(negedge CLK) begin
    tests++;
    if (RAM_WR && RAM_OE) begin
      fails++;
      $display("FAIL wr_oe_overlap: WR=%b OE=%b required not both 1", RAM_WR, RAM_OE);
    end
  end

  // Issue one request from an idle cycle and run to DONE (bounded)
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output int lat, output logic err,
                       output logic [31:0] rd, output int wr_cyc, output int oe_cyc,
                       output logic [31:0] wr_data);
    REQ = 1'b1; WE = we; FUNCT3 = f3; ADDR = a; WDATA = wd;
    wr_cyc = 0; oe_cyc = 0; wr_data = '0;
    @(posedge CLK); #1;
    REQ = 1'b0;
    lat = 1;
    while (!DONE && lat < 10) begin
      if (RAM_WR) begin wr_cyc++; wr_data = RAM_DATA_IN; end
      if (RAM_OE) oe_cyc++;
      @(posedge CLK); #1;
      lat++;
    end
    if (RAM_WR) wr_cyc++;
    if (RAM_OE) oe_cyc++;
    err = ERR;
    rd = RDATA;
  endtask

  task automatic test_reset();
    RSTa = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RSTa = 1'b1;
    #1;
    tests++;
    if ({BUSY, DONE, ERR, RAM_WR, RAM_OE} !== 5'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b required 00000", {BUSY, DONE, ERR, RAM_WR, RAM_OE});
    end
    tests++;
    if (RDATA !== 32'h0 || RAM_DATA_IN !== 32'h0 || RAM_ADDRESS !== '0) begin
      fails++;
      $display("FAIL reset_data: RDATA=%h DIN=%h ADR=%h required all 0", RDATA, RAM_DATA_IN, RAM_ADDRESS);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_word();
    int lat, wc, oc; logic err; logic [31:0] rd, wdat;
    issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, lat, err, rd, wc, oc, wdat);
    tests++;
    if (lat !== 2 || err !== 1'b0 || wc !== 1 || wdat !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL sw_word: lat=%0d err=%b wr=%0d din=%h required 2 0 1 deadbeef", lat, err, wc, wdat);
    end
    issue(1'b0, 3'b010, 32'h10, 32'h0, lat, err, rd, wc, oc, wdat);
    tests++;
    if (lat !== 2 || err !== 1'b0 || rd !== 32'hDEADBEEF || oc !== 1) begin
      fails++;
      $display("FAIL lw_word: lat=%0d err=%b rd=%h oe=%0d required 2 0 deadbeef 1", lat, err, rd, oc);
    end
  endtask

  task automatic test_sub_store();
    int lat, wc, oc; logic err; logic [31:0] rd, wdat;
    mem[8] = 32'h11223344;
    issue(1'b1, 3'b000, 32'h22, 32'h000000AA, lat, err, rd, wc, oc, wdat);
    tests++;
    if (lat !== 3 || err !== 1'b0 || wc !== 1 || wdat !== 32'h11AA3344) begin
      fails++;
      $display("FAIL sb_rmw: lat=%0d err=%b wr=%0d din=%h required 3 0 1 11aa3344", lat, err, wc, wdat);
    end
    issue(1'b0, 3'b010, 32'h20, 32'h0, lat, err, rd, wc, oc, wdat);
    tests++;
    if (rd !== 32'h11AA3344 || err !== 1'b0) begin
      fails++;
      $display("FAIL sb_readback: got %h required 11aa3344", rd);
    end
  endtask

  task automatic test_load_ext();
    int lat, wc, oc; logic err; logic [31:0] rd, wdat;
    logic [2:0]  f3s  [6] = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b101, 3'b000};
    logic [31:0] adrs [6] = '{32'h30, 32'h32, 32'h32, 32'h32, 32'h32, 32'h33};
    logic [31:0] exps [6] = '{32'h00000001, 32'hFFFFFFFF, 32'h000000FF,
                              32'hFFFF80FF, 32'h000080FF, 32'hFFFFFF80};
    mem[12] = 32'h80FF7F01;
    for (int i = 0; i < 6; i++) begin
      issue(1'b0, f3s[i], adrs[i], 32'h0, lat, err, rd, wc, oc, wdat);
      tests++;
      if (rd !== exps[i] || err !== 1'b0 || lat !== 2) begin
        fails++;
        $display("FAIL load_ext[%0d]: rd=%h err=%b lat=%0d required %h 0 2", i, rd, err, lat, exps[i]);
      end
    end
  endtask

  task automatic test_errors();
    int lat, wc, oc; logic err; logic [31:0] rd, wdat;
    logic        wes  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [2:0]  f3s  [5] = '{3'b001, 3'b010, 3'b010, 3'b011, 3'b011};
    logic [31:0] adrs [5] = '{32'h31, 32'h32, 32'h1000, 32'h30, 32'h30};
    issue(1'b0, 3'b010, 32'h30, 32'h0, lat, err, rd, wc, oc, wdat);
    for (int i = 0; i < 5; i++) begin
      issue(wes[i], f3s[i], adrs[i], 32'h55555555, lat, err, rd, wc, oc, wdat);
      tests++;
      if (lat !== 1 || err !== 1'b1 || wc !== 0 || oc !== 0 || rd !== 32'h80FF7F01) begin
        fails++;
        $display("FAIL error[%0d]: lat=%0d err=%b wr=%0d oe=%0d rd=%h required 1 1 0 0 80ff7f01",
                 i, lat, err, wc, oc, rd);
      end
    end
    tests++;
    if (mem[12] !== 32'h80FF7F01) begin
      fails++;
      $display("FAIL error_no_write: got %h required 80ff7f01", mem[12]);
    end
  endtask

  task automatic test_reset_rmw();
    int lat, wc, oc; logic err; logic [31:0] rd, wdat;
    int done_seen = 0;
    mem[16] = 32'h12345678;
    REQ = 1'b1; WE = 1'b1; FUNCT3 = 3'b001; ADDR = 32'h42; WDATA = 32'h0000BEEF;
    @(posedge CLK); #1;
    REQ = 1'b0;
    tests++;
    if (BUSY !== 1'b1 || RAM_OE !== 1'b1) begin
      fails++;
      $display("FAIL rmw_rd_entry: BUSY=%b OE=%b required 1 1", BUSY, RAM_OE);
    end
    RSTa = 1'b0;
    #1;
    tests++;
    if ({BUSY, DONE, ERR, RAM_WR, RAM_OE} !== 5'b0 || RDATA !== 32'h0 ||
        RAM_DATA_IN !== 32'h0 || RAM_ADDRESS !== '0) begin
      fails++;
      $display("FAIL reset_mid_rmw: ctrl=%b rd=%h din=%h adr=%h required all 0",
               {BUSY, DONE, ERR, RAM_WR, RAM_OE}, RDATA, RAM_DATA_IN, RAM_ADDRESS);
    end
    repeat (2) begin
      @(posedge CLK); #1;
      if (DONE) done_seen++;
    end
    RSTa = 1'b1;
    repeat (2) begin
      @(posedge CLK); #1;
      if (DONE) done_seen++;
    end
    tests++;
    if (done_seen !== 0 || mem[16] !== 32'h12345678) begin
      fails++;
      $display("FAIL reset_abort: done=%0d mem=%h required 0 12345678", done_seen, mem[16]);
    end
    issue(1'b0, 3'b010, 32'h40, 32'h0, lat, err, rd, wc, oc, wdat);
    tests++;
    if (rd !== 32'h12345678 || err !== 1'b0) begin
      fails++;
      $display("FAIL reset_readback: got %h required 12345678", rd);
    end
  endtask

  task automatic test_busy_hold();
    logic [3:0] obs;
    REQ = 1'b1; WE = 1'b0; FUNCT3 = 3'b010; ADDR = 32'h10; WDATA = '0;
    @(posedge CLK); #1;
    obs[0] = BUSY && !DONE;
    @(posedge CLK); #1;
    obs[1] = DONE && !BUSY;
    @(posedge CLK); #1;
    obs[2] = BUSY && RAM_OE && !DONE;
    REQ = 1'b0;
    @(posedge CLK); #1;
    obs[3] = DONE && (RDATA === 32'hDEADBEEF);
    tests++;
    if (obs !== 4'b1111) begin
      fails++;
      $display("FAIL busy_hold: got %b required 1111", obs);
    end
    @(posedge CLK); #1;
    tests++;
    if (BUSY !== 1'b0 || DONE !== 1'b0) begin
      fails++;
      $display("FAIL busy_idle: BUSY=%b DONE=%b required 0 0", BUSY, DONE);
    end
  endtask

  task automatic test_back_to_back();
    int lat, wc, oc; logic err; logic [31:0] rd, wdat;
    logic        wes  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [2:0]  f3s  [4] = '{3'b010, 3'b010, 3'b000, 3'b010};
    logic [31:0] adrs [4] = '{32'h10, 32'h50, 32'h51, 32'h50};
    logic [31:0] wds  [4] = '{32'h0, 32'hCAFEF00D, 32'h00000099, 32'h0};
    int          lats [4] = '{2, 2, 3, 2};
    logic [31:0] rds  [4] = '{32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hCAFE990D};
    for (int i = 0; i < 4; i++) begin
      issue(wes[i], f3s[i], adrs[i], wds[i], lat, err, rd, wc, oc, wdat);
      tests++;
      if (lat !== lats[i] || err !== 1'b0 || rd !== rds[i] || BUSY !== 1'b0) begin
        fails++;
        $display("FAIL b2b[%0d]: lat=%0d err=%b rd=%h busy=%b required %0d 0 %h 0",
                 i, lat, err, rd, BUSY, lats[i], rds[i]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    test_reset();
    test_word();
    test_sub_store();
    test_load_ext();
    test_errors();
    test_reset_rmw();
    test_busy_hold();
    test_back_to_back();
    repeat (2) @(posedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
